dio_cfg_sequencer: RTL and testbench

//  Upstream feeder for the digital-I/O control stage. Buffers host-written 16-bit DIO config words, each with a dwell time, in a FIFO.

---
 rtl/dio_cfg_sequencer_if.sv | 23 ++
 rtl/dio_cfg_sequencer.sv | 167 ++++++++++++++++
 tb/tb_dio_cfg_sequencer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dio_cfg_sequencer_if.sv
// Host command / DIO config strobe bundle for dio_cfg_sequencer.
// Latency: none, wiring only.
// Backpressure: cmd_valid/cmd_ready handshake; config_en is a strobe with no back-pressure.
interface dio_cfg_sequencer_if #(
    parameter int DWELL_W = 16
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [15:0]        cmd_data;
    logic [DWELL_W-1:0] cmd_dwell;
    logic               config_en;
    logic [15:0]        config_data;

    modport master (
        output cmd_valid, cmd_data, cmd_dwell,
        input  cmd_ready, config_en, config_data
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_dwell,
        output cmd_ready, config_en, config_data
    );
endinterface

// File: rtl/dio_cfg_sequencer.sv
// Buffers {dwell, config word} entries and replays them as config_en strobes spaced dwell+1 cycles apart.
// Latency: push at edge k into an empty FIFO with run=1 -> config_en in the cycle after edge k+1.
// Backpressure: cmd_ready = !full (also low while looping and busy); optional replay mode under DIO_SEQ_LOOP_EN.
module dio_cfg_sequencer #(
    parameter int DEPTH   = 8,
    parameter int DWELL_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
`ifdef DIO_SEQ_LOOP_EN
    input  logic                       i_loop_mode,
`endif
    input  logic                       i_run,
    input  logic                       i_abort,
    dio_cfg_sequencer_if.slave         bus,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [$clog2(DEPTH+1)-1:0] o_fifo_level
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DWELL_W-1:0] dwell;
        logic [15:0]        data;
    } entry_t;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DWELL} state_t;

    state_t             r_state;
    entry_t             r_mem [DEPTH];
    logic [AW-1:0]      r_wptr, r_rptr;
    logic [LW-1:0]      r_level;
    logic               r_full;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic               r_config_en;
    logic [15:0]        r_config_data;
    logic               r_busy;
    logic               r_done;

    logic               w_loop;
    logic               w_cmd_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_repush;
    logic [AW-1:0]      w_rd_ptr;
    logic [LW-1:0]      w_rem;
    logic [LW-1:0]      w_lvl_nxt;
    logic               w_more;
    entry_t             w_cmd_entry;
    entry_t             w_nxt;
    entry_t             w_wr_entry;

`ifdef DIO_SEQ_LOOP_EN
    assign w_loop = i_loop_mode;
`else
    assign w_loop = 1'b0;
`endif

    // Host may not append while a loop is replaying, so the ring stays fixed.
    assign w_cmd_ready = !r_full && !(w_loop && r_busy);
    assign w_push      = bus.cmd_valid && w_cmd_ready && !i_abort;
    assign w_pop       = (r_state == ST_ISSUE);
    assign w_repush    = w_loop && w_pop;
    assign w_rd_ptr    = r_rptr + AW'(w_pop);
    assign w_rem       = r_level - LW'(w_pop);
    assign w_lvl_nxt   = r_level - LW'(w_pop) + LW'(w_push) + LW'(w_repush);
    assign w_more      = i_run && (w_lvl_nxt != '0);

    // Next entry to issue: stored entry after the pop, else the one being written this cycle.
    always_comb begin
        w_cmd_entry.dwell = bus.cmd_dwell;
        w_cmd_entry.data  = bus.cmd_data;
        w_wr_entry        = w_repush ? r_mem[r_rptr] : w_cmd_entry;
        if (w_rem != '0)
            w_nxt = r_mem[w_rd_ptr];
        else
            w_nxt = w_wr_entry;
    end

    // FIFO pointers, level and registered full flag; abort flushes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_full  <= 1'b0;
        end else if (i_abort) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_push || w_repush)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            r_level <= w_lvl_nxt;
            r_full  <= (w_lvl_nxt == LW'(DEPTH));
        end
    end

    // Entry storage; no reset needed since contents are only read when counted valid.
    always_ff @(posedge clk) begin
        if (!i_abort && (w_push || w_repush))
            r_mem[r_wptr] <= w_wr_entry;
    end

    // Sequencer FSM: strobe on ISSUE, count dwell, then chain, pause or finish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_dwell_cnt   <= '0;
            r_config_en   <= 1'b0;
            r_config_data <= 16'h0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else if (i_abort) begin
            r_state     <= ST_IDLE;
            r_config_en <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_config_en <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_run && (r_level != '0)) begin
                        r_state       <= ST_ISSUE;
                        r_config_en   <= 1'b1;
                        r_config_data <= w_nxt.data;
                        r_dwell_cnt   <= w_nxt.dwell;
                        r_busy        <= 1'b1;
                    end
                end
                ST_ISSUE, ST_DWELL: begin
                    if ((r_state == ST_DWELL) && (r_dwell_cnt > DWELL_W'(1))) begin
                        r_dwell_cnt <= r_dwell_cnt - 1'b1;
                    end else if ((r_state == ST_ISSUE) && (r_dwell_cnt != '0)) begin
                        r_state <= ST_DWELL;
                    end else if (w_more) begin
                        r_state       <= ST_ISSUE;
                        r_config_en   <= 1'b1;
                        r_config_data <= w_nxt.data;
                        r_dwell_cnt   <= w_nxt.dwell;
                    end else begin
                        // Pausing on run=0 with entries left is not a drain.
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= (w_lvl_nxt == '0);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = w_cmd_ready;
    assign bus.config_en   = r_config_en;
    assign bus.config_data = r_config_data;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_fifo_level    = r_level;
endmodule

// File: tb/tb_dio_cfg_sequencer.sv
// Scoreboard bench for dio_cfg_sequencer: expected strobe words queued at push, popped on config_en.
// Latency: strobe timing checked from recorded cycle numbers.
// Backpressure: exercises full FIFO, pause, abort, reset and (with DIO_SEQ_LOOP_EN) replay.
module tb_dio_cfg_sequencer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic run   = 1'b0;
    logic abort = 1'b0;
`ifdef DIO_SEQ_LOOP_EN
    logic loop_mode = 1'b0;
`endif
    logic       busy, done;
    logic [3:0] lvl;

    dio_cfg_sequencer_if #(.DWELL_W(16)) bus();

    dio_cfg_sequencer #(.DEPTH(8), .DWELL_W(16)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef DIO_SEQ_LOOP_EN
        .i_loop_mode  (loop_mode),
`endif
        .i_run        (run),
        .i_abort      (abort),
        .bus          (bus),
        .o_busy       (busy),
        .o_done       (done),
        .o_fifo_level (lvl)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [15:0] exp_q [$];
    int          scyc  [$];
    int          dcyc  [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && bus.config_en) begin
            scyc.push_back(cyc);
            if (exp_q.size() == 0)
                chk("unexpected_strobe", {16'h0, bus.config_data}, 32'hFFFF_FFFF);
            else
                chk("strobe_data", {16'h0, bus.config_data}, {16'h0, exp_q.pop_front()});
        end
        if (rst_n && done)
            dcyc.push_back(cyc);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic [15:0] dw);
        int n;
        n = 0;
        step();
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = d;
        bus.cmd_dwell = dw;
        while (!bus.cmd_ready && n < 200) begin
            step();
            n++;
        end
        chk("push_accept", {31'h0, bus.cmd_ready}, 32'h1);
        if (bus.cmd_ready)
            exp_q.push_back(d);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        step();
        while ((busy || exp_q.size() != 0 || lvl != 0) && n < max) begin
            step();
            n++;
        end
        chk("drain_in_time", {31'h0, n < max}, 32'h1);
    endtask

    task automatic wait_strobe(input int cnt, input string tag);
        int n;
        n = 0;
        while (scyc.size() < cnt && n < 100) begin
            step();
            n++;
        end
        chk(tag, {31'h0, scyc.size() >= cnt}, 32'h1);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, db, ns, bb;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 16'h0;
        bus.cmd_dwell = 16'h0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_en",    {31'h0, bus.config_en}, 32'h0);
        chk("rst_data",  {16'h0, bus.config_data}, 32'h0);
        chk("rst_busy",  {31'h0, busy}, 32'h0);
        chk("rst_done",  {31'h0, done}, 32'h0);
        chk("rst_level", {28'h0, lvl}, 32'h0);
        chk("rst_ready", {31'h0, bus.cmd_ready}, 32'h1);
        rst_n = 1'b1;
        step();

        // 1: back-to-back strobes with zero dwell
        b = scyc.size(); db = dcyc.size();
        run = 1'b1;
        push(16'h8000, 16'd0);
        push(16'h4000, 16'd0);
        push(16'hC123, 16'd0);
        drain(100);
        chk("t1_nstrobe", scyc.size() - b, 3);
        chk("t1_ndone", dcyc.size() - db, 1);
        chk("t1_level", {28'h0, lvl}, 32'h0);
        if (scyc.size() - b == 3 && dcyc.size() - db == 1) begin
            chk("t1_gap1", scyc[b+1] - scyc[b], 1);
            chk("t1_gap2", scyc[b+2] - scyc[b+1], 1);
            chk("t1_done_time", dcyc[db], scyc[b+2] + 1);
        end

        // 2: dwell of 3 spaces strobes 4 cycles apart
        b = scyc.size(); db = dcyc.size(); bb = 0;
        push(16'h8000, 16'd3);
        push(16'h0000, 16'd0);
        ns = 0;
        while (scyc.size() < b + 2 && ns < 50) begin
            step();
            ns++;
            if (scyc.size() > b && busy !== 1'b1) bb++;
        end
        chk("t2_busy_hold", bb, 0);
        drain(50);
        chk("t2_nstrobe", scyc.size() - b, 2);
        chk("t2_ndone", dcyc.size() - db, 1);
        if (scyc.size() - b == 2 && dcyc.size() - db == 1) begin
            chk("t2_gap", scyc[b+1] - scyc[b], 4);
            chk("t2_done_time", dcyc[db], scyc[b+1] + 1);
        end

        // 3: fill with run low, extra offer ignored, ready back after first pop
        run = 1'b0;
        b = scyc.size(); db = dcyc.size();
        for (int i = 0; i < 8; i++) push(16'h3000 + 16'(i), 16'd0);
        step();
        chk("t3_ready_full", {31'h0, bus.cmd_ready}, 32'h0);
        chk("t3_level_full", {28'h0, lvl}, 32'd8);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 16'hDEAD;
        repeat (3) step();
        chk("t3_level_hold", {28'h0, lvl}, 32'd8);
        bus.cmd_valid = 1'b0;
        run = 1'b1;
        wait_strobe(b + 1, "t3_first_strobe");
        chk("t3_ready_at_pop", {31'h0, bus.cmd_ready}, 32'h0);
        step();
        chk("t3_ready_after", {31'h0, bus.cmd_ready}, 32'h1);
        drain(100);
        chk("t3_nstrobe", scyc.size() - b, 8);
        chk("t3_ndone", dcyc.size() - db, 1);
        bb = 0;
        for (int i = b + 1; i < scyc.size(); i++)
            if (scyc[i] - scyc[i-1] != 1) bb++;
        chk("t3_gaps", bb, 0);

        // 4: pause mid-dwell, then resume
        run = 1'b0;
        b = scyc.size(); db = dcyc.size();
        push(16'h4A4A, 16'd5);
        push(16'h4B4B, 16'd0);
        push(16'h4C4C, 16'd0);
        step();
        run = 1'b1;
        wait_strobe(b + 1, "t4_first_strobe");
        step();
        run = 1'b0;
        repeat (10) step();
        chk("t4_paused_nstrobe", scyc.size() - b, 1);
        chk("t4_paused_ndone", dcyc.size() - db, 0);
        chk("t4_paused_busy", {31'h0, busy}, 32'h0);
        chk("t4_paused_level", {28'h0, lvl}, 32'd2);
        run = 1'b1;
        drain(100);
        chk("t4_nstrobe", scyc.size() - b, 3);
        chk("t4_ndone", dcyc.size() - db, 1);

        // 5: abort during dwell, with a push offered in the abort cycle
        run = 1'b0;
        b = scyc.size(); db = dcyc.size();
        push(16'h5A5A, 16'd6);
        push(16'h5B5B, 16'd0);
        push(16'h5C5C, 16'd0);
        push(16'h5D5D, 16'd0);
        step();
        run = 1'b1;
        wait_strobe(b + 1, "t5_first_strobe");
        step();
        step();
        abort         = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 16'hEEEE;
        bus.cmd_dwell = 16'd0;
        step();
        abort         = 1'b0;
        bus.cmd_valid = 1'b0;
        exp_q.delete();
        chk("t5_level", {28'h0, lvl}, 32'h0);
        chk("t5_busy", {31'h0, busy}, 32'h0);
        chk("t5_en", {31'h0, bus.config_en}, 32'h0);
        chk("t5_data_hold", {16'h0, bus.config_data}, 32'h5A5A);
        chk("t5_done", {31'h0, done}, 32'h0);
        ns = scyc.size();
        repeat (8) step();
        chk("t5_no_strobe", scyc.size() - ns, 0);
        chk("t5_ndone", dcyc.size() - db, 0);

        // Reset mid-sequence
        b = scyc.size();
        push(16'h7777, 16'd3);
        push(16'h7878, 16'd0);
        wait_strobe(b + 1, "rst_mid_strobe");
        step();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_data", {16'h0, bus.config_data}, 32'h0);
        chk("rst_mid_level", {28'h0, lvl}, 32'h0);
        chk("rst_mid_busy", {31'h0, busy}, 32'h0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        ns = scyc.size();
        repeat (6) step();
        chk("rst_mid_no_strobe", scyc.size() - ns, 0);

`ifdef DIO_SEQ_LOOP_EN
        // 6: loop replay A,B,A,B..., then drain once after clearing loop_mode
        run = 1'b0;
        b = scyc.size(); db = dcyc.size(); bb = 0;
        push(16'hA1A1, 16'd1);
        push(16'hB2B2, 16'd1);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(16'hA1A1);
            exp_q.push_back(16'hB2B2);
        end
        step();
        loop_mode = 1'b1;
        run       = 1'b1;
        ns = 0;
        while (scyc.size() < b + 6 && ns < 100) begin
            step();
            ns++;
            if (busy && (bus.cmd_ready !== 1'b0 || lvl != 4'd2)) bb++;
        end
        chk("t6_loop_ready_level", bb, 0);
        @(posedge clk);
        #1;
        loop_mode = 1'b0;
        drain(100);
        chk("t6_nstrobe", scyc.size() - b, 8);
        chk("t6_ndone", dcyc.size() - db, 1);
        bb = 0;
        for (int i = b + 1; i < scyc.size(); i++)
            if (scyc[i] - scyc[i-1] != 2) bb++;
        chk("t6_gaps", bb, 0);
`endif

        chk("exp_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
